// File: rtl/demux_1x4_stream_if.sv
// Handshake bundle for demux_1x4_stream: one valid/ready input stream, four registered output lanes.
// master drives the producer side and the lane readies; slave is the demultiplexer.
interface demux_1x4_stream_if #(
  parameter int WIDTH     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic [SEL_WIDTH-1:0] sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     data_out_0;
  logic [WIDTH-1:0]     data_out_1;
  logic [WIDTH-1:0]     data_out_2;
  logic [WIDTH-1:0]     data_out_3;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [CNT_WIDTH-1:0] cnt_0;
  logic [CNT_WIDTH-1:0] cnt_1;
  logic [CNT_WIDTH-1:0] cnt_2;
  logic [CNT_WIDTH-1:0] cnt_3;

  modport master (
    output data_in, sel, in_valid, out_ready,
    input  in_ready, data_out_0, data_out_1, data_out_2, data_out_3, out_valid,
    input  cnt_0, cnt_1, cnt_2, cnt_3
  );

  modport slave (
    input  data_in, sel, in_valid, out_ready,
    output in_ready, data_out_0, data_out_1, data_out_2, data_out_3, out_valid,
    output cnt_0, cnt_1, cnt_2, cnt_3
  );
endinterface

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 valid/ready demux, 1-cycle latency; per-lane counters under DEMUX_1X4_STREAM_COUNT_EN.
// in_ready drops only while the selected lane holds a word its consumer is not taking.
module demux_1x4_stream #(
  parameter int WIDTH     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  demux_1x4_stream_if.slave bus
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       vld_q;
  logic [3:0]       load;
  logic             ready;
  logic             xfer;

  // A full lane still accepts when it drains in the same cycle.
  assign ready = !vld_q[bus.sel] || bus.out_ready[bus.sel];
  assign xfer  = bus.in_valid && ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < 4; k++) begin
      load[k] = xfer && (bus.sel == SEL_WIDTH'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.data_in;
        end
      end
      vld_q <= load | (vld_q & ~bus.out_ready);
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = vld_q;
  assign bus.data_out_0 = data_q[0];
  assign bus.data_out_1 = data_q[1];
  assign bus.data_out_2 = data_q[2];
  assign bus.data_out_3 = data_q[3];

`ifdef DEMUX_1X4_STREAM_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign bus.cnt_0 = cnt_q[0];
  assign bus.cnt_1 = cnt_q[1];
  assign bus.cnt_2 = cnt_q[2];
  assign bus.cnt_3 = cnt_q[3];
`else
  assign bus.cnt_0 = '0;
  assign bus.cnt_1 = '0;
  assign bus.cnt_2 = '0;
  assign bus.cnt_3 = '0;
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Bench for demux_1x4_stream: lane-occupancy reference model, per-cycle compare, directed and random traffic.
`timescale 1ns/1ps
module tb_demux_1x4_stream;
  localparam int WIDTH     = 4;
  localparam int SEL_WIDTH = 2;
  localparam int CNT_WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  demux_1x4_stream_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  demux_1x4_stream #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  // Reference: each lane is a one-word slot; occ = words held, last = most recent word written.
  int   occ   [4];
  int   xfers [4];
  logic [WIDTH-1:0] last [4];

  initial begin
    for (int k = 0; k < 4; k++) begin
      occ[k] = 0; xfers[k] = 0; last[k] = '0;
    end
  end

  function automatic logic model_ready();
    return (occ[bus.sel] == 0) || bus.out_ready[bus.sel];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] model_cnt(input int k);
`ifdef DEMUX_1X4_STREAM_COUNT_EN
    return CNT_WIDTH'(xfers[k] % (1 << CNT_WIDTH));
`else
    return CNT_WIDTH'(0 * xfers[k]);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        occ[k] = 0; xfers[k] = 0; last[k] = '0;
      end
    end else begin
      logic acc;
      int   s;
      acc = bus.in_valid && model_ready();
      s   = int'(bus.sel);
      for (int k = 0; k < 4; k++) begin
        if (occ[k] > 0 && bus.out_ready[k]) occ[k] = occ[k] - 1;
      end
      if (acc) begin
        occ[s]   = occ[s] + 1;
        last[s]  = bus.data_in;
        xfers[s] = xfers[s] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare, midway between the falling edge (inputs change) and the next rising edge.
  always @(negedge clk) begin
    if (!done) begin
      logic [3:0] exp_ov;
      #5;
      for (int k = 0; k < 4; k++) exp_ov[k] = (occ[k] > 0);
      chk("m_in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("m_data0", 32'(bus.data_out_0), 32'(last[0]));
      chk("m_data1", 32'(bus.data_out_1), 32'(last[1]));
      chk("m_data2", 32'(bus.data_out_2), 32'(last[2]));
      chk("m_data3", 32'(bus.data_out_3), 32'(last[3]));
      chk("m_cnt0", 32'(bus.cnt_0), 32'(model_cnt(0)));
      chk("m_cnt1", 32'(bus.cnt_1), 32'(model_cnt(1)));
      chk("m_cnt2", 32'(bus.cnt_2), 32'(model_cnt(2)));
      chk("m_cnt3", 32'(bus.cnt_3), 32'(model_cnt(3)));
    end
  end

  // Drive at the falling edge, return 5ns later so literal checks see this cycle's in_ready.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.data_in   = d;
    bus.out_ready = r;
    #5;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #5;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_data", 32'({bus.data_out_3, bus.data_out_2, bus.data_out_1, bus.data_out_0}), 32'h0);
    chk("rst_cnt", 32'({bus.cnt_3, bus.cnt_2, bus.cnt_1, bus.cnt_0}), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic stalled;
    logic [CNT_WIDTH-1:0] exp_wrap;
    bus.in_valid = 1'b0; bus.sel = '0; bus.data_in = '0; bus.out_ready = 4'hF;
    do_reset();

    // Sequential routing: one-hot words to lanes 0..3.
    cyc(1, 2'd0, 4'b0001, 4'hF); chk("seq_rdy", 32'(bus.in_ready), 32'h1);
    cyc(1, 2'd1, 4'b0010, 4'hF); chk("seq_ov0", 32'(bus.out_valid), 32'b0001); chk("seq_d0", 32'(bus.data_out_0), 32'b0001);
    cyc(1, 2'd2, 4'b0100, 4'hF); chk("seq_ov1", 32'(bus.out_valid), 32'b0010); chk("seq_d1", 32'(bus.data_out_1), 32'b0010);
    cyc(1, 2'd3, 4'b1000, 4'hF); chk("seq_ov2", 32'(bus.out_valid), 32'b0100); chk("seq_d2", 32'(bus.data_out_2), 32'b0100);
    cyc(0, 2'd0, 4'b0000, 4'hF); chk("seq_ov3", 32'(bus.out_valid), 32'b1000); chk("seq_d3", 32'(bus.data_out_3), 32'b1000);
    cyc(0, 2'd0, 4'b0000, 4'hF); chk("seq_idle", 32'(bus.out_valid), 32'b0000);

    // Backpressure isolation: lane 0 stalls, lane 2 still accepts.
    cyc(1, 2'd0, 4'b1111, 4'b1110); chk("bp_rdy1", 32'(bus.in_ready), 32'h1);
    cyc(1, 2'd0, 4'b1010, 4'b1110); chk("bp_stall", 32'(bus.in_ready), 32'h0); chk("bp_hold", 32'(bus.data_out_0), 32'hF);
    cyc(1, 2'd0, 4'b1010, 4'b1110); chk("bp_stall2", 32'(bus.in_ready), 32'h0);
    cyc(1, 2'd2, 4'b0101, 4'b1110); chk("bp_retarget", 32'(bus.in_ready), 32'h1);
    cyc(1, 2'd0, 4'b1010, 4'b1110); chk("bp_ov", 32'(bus.out_valid), 32'b0101); chk("bp_d2", 32'(bus.data_out_2), 32'h5);
    chk("bp_hold2", 32'(bus.data_out_0), 32'hF);
    cyc(1, 2'd0, 4'b1010, 4'b1111); chk("bp_release", 32'(bus.in_ready), 32'h1);
    cyc(0, 2'd0, 4'b0000, 4'b1111); chk("bp_d0", 32'(bus.data_out_0), 32'hA); chk("bp_ov0", 32'(bus.out_valid), 32'b0001);

    // Full throughput on lane 3.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'd3, 4'(i), 4'b1000);
      chk("ft_rdy", 32'(bus.in_ready), 32'h1);
      if (i > 0) begin
        chk("ft_vld", 32'(bus.out_valid[3]), 32'h1);
        chk("ft_dat", 32'(bus.data_out_3), 32'(i - 1));
      end
    end
    cyc(0, 2'd0, 4'h0, 4'b1000); chk("ft_last", 32'(bus.data_out_3), 32'h7); chk("ft_vld_last", 32'(bus.out_valid), 32'b1000);
    cyc(0, 2'd0, 4'h0, 4'b1000); chk("ft_drained", 32'(bus.out_valid), 32'b0000);

    // Random traffic; producer holds its word while stalled.
    stalled = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r;
      r = 4'($urandom) | 4'($urandom);
      if (stalled) cyc(bus.in_valid, bus.sel, bus.data_in, r);
      else         cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), r);
      stalled = bus.in_valid && !bus.in_ready;
    end

    // Counter wrap on lane 1.
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1, 2'd1, 4'(i), 4'hF);
    cyc(0, 2'd0, 4'h0, 4'hF);
    exp_wrap = '0;
    chk("wrap_cnt1", 32'(bus.cnt_1), 32'(exp_wrap));
    chk("wrap_others", 32'({bus.cnt_3, bus.cnt_2, bus.cnt_0}), 32'h0);
    cyc(1, 2'd1, 4'h9, 4'hF);
    cyc(0, 2'd0, 4'h0, 4'hF);
`ifdef DEMUX_1X4_STREAM_COUNT_EN
    exp_wrap = 8'd1;
`else
    exp_wrap = 8'd0;
`endif
    chk("wrap_plus1", 32'(bus.cnt_1), 32'(exp_wrap));

    // Asynchronous reset between edges with three lanes stalled.
    cyc(1, 2'd0, 4'h1, 4'h0);
    cyc(1, 2'd1, 4'h2, 4'h0);
    cyc(1, 2'd2, 4'h3, 4'h0);
    cyc(0, 2'd0, 4'h0, 4'h0); chk("mid_loaded", 32'(bus.out_valid), 32'b0111);
    #2 rst = 1'b1;
    #1;
    chk("mid_ov", 32'(bus.out_valid), 32'h0);
    chk("mid_cnt", 32'({bus.cnt_3, bus.cnt_2, bus.cnt_1, bus.cnt_0}), 32'h0);
    chk("mid_data", 32'({bus.data_out_3, bus.data_out_2, bus.data_out_1, bus.data_out_0}), 32'h0);
    chk("mid_rdy", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 2'd0, 4'h9, 4'hF); chk("post_rdy", 32'(bus.in_ready), 32'h1);
    cyc(0, 2'd0, 4'h0, 4'h0); chk("post_ov", 32'(bus.out_valid), 32'b0001); chk("post_d0", 32'(bus.data_out_0), 32'h9);
`ifdef DEMUX_1X4_STREAM_COUNT_EN
    exp_wrap = 8'd1;
`else
    exp_wrap = 8'd0;
`endif
    chk("post_cnt0", 32'(bus.cnt_0), 32'(exp_wrap));

    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1x4_stream.md
# demux_1x4_stream

Registered 1-to-4 stream demultiplexer: the write-side counterpart to `mux_4x1`. A single valid/ready input stream is steered by `sel` into one of four independent output channels. Each channel has its own one-entry output register and valid/ready handshake. The block sits upstream of per-channel consumers, fanning one producer out to four lanes with backpressure isolated per lane.

## Interface
- `WIDTH`, default 4: data width of the input and of every output channel.
- `SEL_WIDTH`, default 2: select width; fixed at 2 for four channels.
- `CNT_WIDTH`, default 8: width of each per-channel transfer counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  WIDTH  input payload.
- `sel`  in  SEL_WIDTH  destination channel for `data_in`.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle when high with `in_valid`.
- `data_out_0`..`data_out_3`  out  WIDTH  channel output registers.
- `out_valid`  out  4  bit k high means `data_out_k` holds an unconsumed word.
- `out_ready`  in  4  bit k high means the consumer on channel k takes the word.
- `cnt_0`..`cnt_3`  out  CNT_WIDTH  per-channel transfer counters (see Configuration).

## Operation
- Input handshake: a transfer occurs when `in_valid && in_ready`.
- `in_ready = !out_valid[sel] || out_ready[sel]`. This is combinational on `sel` and `out_ready`; there is no path from `in_valid` to `in_ready`.
- On transfer: `data_out_<sel>` ← `data_in` and `out_valid[sel]` ← 1.
- Output handshake on channel k occurs when `out_valid[k] && out_ready[k]`. If there is no input transfer into k in the same cycle, `out_valid[k]` ← 0.
- Same cycle, load and drain on channel k: the register reloads and `out_valid[k]` stays 1, giving full throughput of one word per cycle per channel.
- Load into channel j while channel k≠j drains: the two channels are fully independent.
- Non-selected channels never change their data.
- `data_out_k` holds its last value after draining; its content is meaningless while `out_valid[k]` is 0.
- Producer rule: `data_in` and `sel` stay stable while `in_valid && !in_ready`. The block does not check this. Changing `sel` while stalled retargets the word, which is legal but outside spec.
- Reset, asynchronous, including mid-transfer:
  - all `data_out_k` = 0, `out_valid` = 4'b0000, all `cnt_k` = 0.
  - `in_ready` then reads 1.
  - Words held in output registers are discarded.

## Timing
- Latency is 1 cycle: a word accepted at edge N shows on `data_out_<sel>` with its `out_valid` bit high after edge N.
- Throughput is one word per cycle aggregate, with back-to-back transfers allowed to the same or different channels.
- A stalled channel (`out_valid[k]=1`, `out_ready[k]=0`) blocks the input only while `sel==k`. Other destinations proceed without penalty.
- All outputs except `in_ready` are registered.

## Configuration
- Macro `DEMUX_1X4_STREAM_COUNT_EN`.
- Defined:
  - `cnt_k` increments by 1 on every input transfer into channel k.
  - Counters wrap modulo 2^CNT_WIDTH, so 255 → 0 at the default width.
  - Counters are cleared only by `rst`.
- Undefined:
  - no counter flops are built.
  - `cnt_0`..`cnt_3` are tied to 0.
  - Datapath and handshake behaviour are identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles at any state.
  - Required: `out_valid`=0000, all `data_out_k`=0, `in_ready`=1, counters 0.
- **Sequential routing:**
  - Stimulus: `out_ready`=1111, then send `sel`=0..3 with `data_in`=0001, 0010, 0100, 1000 on consecutive cycles.
  - Required: each value appears on the matching `data_out_k` one cycle later, with only that `out_valid` bit pulsed.
- **Backpressure isolation:**
  - Stimulus: `out_ready`=1110, send 1111 to ch0, then 1010 to ch0, then 0101 to ch2.
  - Required: the second ch0 word stalls (`in_ready`=0) and `data_out_0` holds 1111.
  - Required: after retargeting the stimulus, ch2 receives 0101 the next cycle.
  - Required: raising `out_ready[0]` releases 1010 to ch0.
- **Full throughput:**
  - Stimulus: ch3 with `out_ready[3]`=1 held, 8 back-to-back words 0..7.
  - Required: `in_ready` stays 1, `out_valid[3]` stays 1 for 8 cycles, and data reads 0..7 in order.
- **Counter wrap** (with `DEMUX_1X4_STREAM_COUNT_EN`):
  - Stimulus: 256 transfers into ch1.
  - Required: `cnt_1` = 0, others 0.
  - Required: one more transfer gives `cnt_1` = 1.
  - Without the macro, all `cnt_k` stay 0.
- **Reset mid-operation:**
  - Stimulus: ch0..ch2 loaded and stalled, assert `rst` asynchronously between edges.
  - Required: `out_valid` drops to 0000 immediately and counters clear.
  - Required: the first post-reset transfer behaves as from a fresh start.
